rsa_word_serdes: RTL and testbench

Bridges the 256-bit Avalon-side data path and the byte-serial RSA core port. Load direction: accepts a 256-bit word tagged with a core register select, then writes it into the core one byte per address step. Unload direction: on request, reads 32 result bytes from the core and packs them into a 256-bit word for the DRAM write path. Sits directly between the Avalon-MM master/FSM wrapper and `rsa_core`. Runs entirely on `clk`; the slow core rate is met by holding each address for `STEP_CYCLES`, not by a second clock.

---
 rtl/rsa_serdes_pkg.sv | 21 ++
 rtl/rsa_step_gen.sv | 57 +++++
 rtl/rsa_word_serdes.sv | 162 ++++++++++++++++
 tb/tb_rsa_word_serdes.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rsa_serdes_pkg.sv
// Shared types and constants for the 256-bit <-> byte-serial RSA core bridge.
package rsa_serdes_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_UNLOAD,
    ST_DRAIN,
    ST_HOLD
  } state_t;

  localparam int WORD_BYTES = 32;

  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_MSG  = 2'b01;
  localparam logic [1:0] SEL_EXP  = 2'b10;
  localparam logic [1:0] SEL_MOD  = 2'b11;

  localparam logic [4:0] LAST_ADDR = 5'(WORD_BYTES - 1);

endpackage

// File: rtl/rsa_step_gen.sv
// Step strobe every STEP_CYCLES clocks plus a saturating 5-bit byte address.
module rsa_step_gen
  import rsa_serdes_pkg::*;
#(
  parameter int STEP_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_en,
  input  logic       i_clr,
  output logic       o_step,
  output logic       o_first,
  output logic       o_last,
  output logic [4:0] o_addr,
  output logic [4:0] o_addr_next
);

  localparam logic [2:0] STEP_LAST = 3'(STEP_CYCLES - 1);

  logic [2:0] r_cnt;
  logic [4:0] r_addr;
  logic [2:0] w_cnt_next;
  logic [4:0] w_addr_next;

  always_comb begin
    o_step  = i_en && (r_cnt == STEP_LAST);
    o_first = (r_cnt == 3'd0);
    o_last  = (r_addr == LAST_ADDR);
    o_addr  = r_addr;
    w_cnt_next  = r_cnt;
    w_addr_next = r_addr;
    if (i_clr) begin
      w_cnt_next  = 3'd0;
      w_addr_next = 5'd0;
    end else if (i_en) begin
      if (o_step) begin
        w_cnt_next = 3'd0;
        // Saturate so the bridge can keep showing the final address while draining.
        if (!o_last) w_addr_next = r_addr + 5'd1;
      end else begin
        w_cnt_next = r_cnt + 3'd1;
      end
    end
    o_addr_next = w_addr_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt  <= 3'd0;
      r_addr <= 5'd0;
    end else begin
      r_cnt  <= w_cnt_next;
      r_addr <= w_addr_next;
    end
  end

endmodule

// File: rtl/rsa_word_serdes.sv
// 256-bit word <-> byte-serial RSA core bridge (load and unload directions).
// Define RSA_SERDES_BSWAP_EN to map core byte k to word bits [255-8k:248-8k].
module rsa_word_serdes
  import rsa_serdes_pkg::*;
#(
  parameter int STEP_CYCLES = 2,
  parameter int RD_LAT      = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [255:0] in_data,
  input  logic [1:0]   in_sel,
  input  logic         unload_req,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [255:0] out_data,
  output logic         core_we,
  output logic         core_oe,
  output logic [1:0]   core_reg_sel,
  output logic [4:0]   core_addr,
  output logic [7:0]   core_data_i,
  input  logic [7:0]   core_data_o,
  output logic         busy
);

`ifdef RSA_SERDES_BSWAP_EN
  localparam bit BSWAP = 1'b1;
`else
  localparam bit BSWAP = 1'b0;
`endif

  state_t r_state, w_state_next;

  logic [255:0] r_word;
  logic [1:0]   r_sel;
  logic         r_core_we, r_core_oe, r_out_valid, r_got31;
  logic [1:0]   r_core_reg_sel;
  logic [7:0]   r_core_data_i;
  logic [255:0] r_pack;
  logic [RD_LAT-1:0]      r_vpipe;
  logic [RD_LAT-1:0][4:0] r_ipipe;

  logic         w_step, w_first, w_last, w_sg_en, w_sg_clr;
  logic [4:0]   w_addr, w_addr_next;
  logic         w_cap_valid, w_cap31, w_first_fire, w_pack_clr;
  logic [4:0]   w_cap_idx, w_cap_slot, w_byte_slot;
  logic         w_we_next, w_oe_next, w_out_valid_next;
  logic [1:0]   w_reg_sel_next;
  logic [7:0]   w_data_i_next;
  logic [255:0] w_src_word;

  rsa_step_gen #(
    .STEP_CYCLES(STEP_CYCLES)
  ) u_step (
    .clk        (clk),
    .reset      (reset),
    .i_en       (w_sg_en),
    .i_clr      (w_sg_clr),
    .o_step     (w_step),
    .o_first    (w_first),
    .o_last     (w_last),
    .o_addr     (w_addr),
    .o_addr_next(w_addr_next)
  );

  assign w_cap_valid = r_vpipe[RD_LAT-1];
  assign w_cap_idx   = r_ipipe[RD_LAT-1];
  assign w_cap31     = w_cap_valid && (w_cap_idx == LAST_ADDR);
  assign w_cap_slot  = BSWAP ? (LAST_ADDR - w_cap_idx) : w_cap_idx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (in_valid)        w_state_next = ST_LOAD;
        else if (unload_req) w_state_next = ST_UNLOAD;
      end
      ST_LOAD:   if (w_step && w_last) w_state_next = ST_IDLE;
      ST_UNLOAD: if (w_step && w_last) w_state_next = (r_got31 || w_cap31) ? ST_HOLD : ST_DRAIN;
      ST_DRAIN:  if (w_cap31) w_state_next = ST_HOLD;
      ST_HOLD:   if (out_ready) w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  // Registered outputs are computed from the next state so they align with it.
  always_comb begin
    w_sg_en          = (r_state == ST_LOAD) || (r_state == ST_UNLOAD);
    w_sg_clr         = (w_state_next == ST_IDLE) || (w_state_next == ST_HOLD);
    w_first_fire     = (r_state == ST_UNLOAD) && w_first;
    w_pack_clr       = (r_state == ST_IDLE) && (w_state_next == ST_UNLOAD);
    w_we_next        = (w_state_next == ST_LOAD);
    w_oe_next        = (w_state_next == ST_UNLOAD) || (w_state_next == ST_DRAIN);
    w_out_valid_next = (w_state_next == ST_HOLD);
    w_src_word       = (r_state == ST_IDLE) ? in_data : r_word;
    w_byte_slot      = BSWAP ? (LAST_ADDR - w_addr_next) : w_addr_next;
    w_reg_sel_next   = SEL_NONE;
    w_data_i_next    = 8'd0;
    if (w_we_next) begin
      w_reg_sel_next = (r_state == ST_IDLE) ? in_sel : r_sel;
      w_data_i_next  = w_src_word[8*w_byte_slot +: 8];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_word         <= '0;
      r_sel          <= SEL_NONE;
      r_core_we      <= 1'b0;
      r_core_oe      <= 1'b0;
      r_core_reg_sel <= SEL_NONE;
      r_core_data_i  <= 8'd0;
      r_out_valid    <= 1'b0;
      r_pack         <= '0;
      r_got31        <= 1'b0;
      r_vpipe        <= '0;
      r_ipipe        <= '0;
    end else begin
      if ((r_state == ST_IDLE) && in_valid) begin
        r_word <= in_data;
        r_sel  <= in_sel;
      end
      r_core_we      <= w_we_next;
      r_core_oe      <= w_oe_next;
      r_core_reg_sel <= w_reg_sel_next;
      r_core_data_i  <= w_data_i_next;
      r_out_valid    <= w_out_valid_next;
      // Delay line tags each address's first cycle so capture lands RD_LAT later.
      r_vpipe[0] <= w_first_fire;
      r_ipipe[0] <= w_addr;
      for (int i = 1; i < RD_LAT; i++) begin
        r_vpipe[i] <= r_vpipe[i-1];
        r_ipipe[i] <= r_ipipe[i-1];
      end
      if (w_pack_clr) begin
        r_pack  <= '0;
        r_got31 <= 1'b0;
      end else if (w_cap_valid) begin
        r_pack[8*w_cap_slot +: 8] <= core_data_o;
        if (w_cap31) r_got31 <= 1'b1;
      end
    end
  end

  assign in_ready     = (r_state == ST_IDLE);
  assign busy         = (r_state != ST_IDLE);
  assign out_valid    = r_out_valid;
  assign out_data     = r_pack;
  assign core_we      = r_core_we;
  assign core_oe      = r_core_oe;
  assign core_reg_sel = r_core_reg_sel;
  assign core_addr    = w_addr;
  assign core_data_i  = r_core_data_i;

endmodule

// File: tb/tb_rsa_word_serdes.sv
// Directed bench: dut_a (STEP=2, RD_LAT=3) for load/arbitration/reset, dut_b (STEP=1, RD_LAT=3) for unload.
module tb_rsa_word_serdes;
  import rsa_serdes_pkg::*;

  localparam int A_STEP = 2;
  localparam int B_STEP = 1;
  localparam int LAT    = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic         in_valid = 1'b0, in_valid_b = 1'b0;
  logic [255:0] in_data = '0;
  logic [1:0]   in_sel = SEL_NONE;
  logic         unload_req_a = 1'b0, unload_req_b = 1'b0;
  logic         out_ready_a = 1'b1, out_ready_b = 1'b0;

  logic         a_in_ready, a_out_valid, a_core_we, a_core_oe, a_busy;
  logic [255:0] a_out_data;
  logic [1:0]   a_core_reg_sel;
  logic [4:0]   a_core_addr;
  logic [7:0]   a_core_data_i, a_core_data_o;
  logic         b_in_ready, b_out_valid, b_core_we, b_core_oe, b_busy;
  logic [255:0] b_out_data;
  logic [1:0]   b_core_reg_sel;
  logic [4:0]   b_core_addr;
  logic [7:0]   b_core_data_i, b_core_data_o;

  rsa_word_serdes #(.STEP_CYCLES(A_STEP), .RD_LAT(LAT)) dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_data(in_data), .in_sel(in_sel), .unload_req(unload_req_a),
    .out_valid(a_out_valid), .out_ready(out_ready_a), .out_data(a_out_data),
    .core_we(a_core_we), .core_oe(a_core_oe), .core_reg_sel(a_core_reg_sel),
    .core_addr(a_core_addr), .core_data_i(a_core_data_i),
    .core_data_o(a_core_data_o), .busy(a_busy));

  rsa_word_serdes #(.STEP_CYCLES(B_STEP), .RD_LAT(LAT)) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid_b), .in_ready(b_in_ready),
    .in_data(in_data), .in_sel(in_sel), .unload_req(unload_req_b),
    .out_valid(b_out_valid), .out_ready(out_ready_b), .out_data(b_out_data),
    .core_we(b_core_we), .core_oe(b_core_oe), .core_reg_sel(b_core_reg_sel),
    .core_addr(b_core_addr), .core_data_i(b_core_data_i),
    .core_data_o(b_core_data_o), .busy(b_busy));

  // Core read model: data for an address appears LAT cycles after it is presented.
  logic [4:0] a_pipe [LAT];
  logic [4:0] b_pipe [LAT];
  always @(posedge clk) begin
    a_pipe[0] <= a_core_addr;
    b_pipe[0] <= b_core_addr;
    for (int i = 1; i < LAT; i++) begin
      a_pipe[i] <= a_pipe[i-1];
      b_pipe[i] <= b_pipe[i-1];
    end
  end
  assign a_core_data_o = 8'hA0 + {3'b000, a_pipe[LAT-1]};
  assign b_core_data_o = 8'hA0 + {3'b000, b_pipe[LAT-1]};

  int n_err = 0;
  int n_chk = 0;

  function automatic logic [7:0] byte_of(logic [255:0] w, int k);
`ifdef RSA_SERDES_BSWAP_EN
    return w[255-8*k -: 8];
`else
    return w[8*k +: 8];
`endif
  endfunction

  function automatic logic [255:0] unload_word();
    logic [255:0] w;
    w = '0;
    for (int k = 0; k < WORD_BYTES; k++) begin
`ifdef RSA_SERDES_BSWAP_EN
      w[255-8*k -: 8] = 8'(8'hA0 + k);
`else
      w[8*k +: 8] = 8'(8'hA0 + k);
`endif
    end
    return w;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [1:0]   sel;
    logic [255:0] data;
    logic [7:0]   exp_first;
    logic [7:0]   exp_last;
  } load_vec_t;

  load_vec_t lv [3];

  initial begin
    int n;
    int stray;
    logic [7:0] first_b, last_b;

    lv[0] = '{SEL_EXP, 256'h201f1e1d1c1b1a191817161514131211100f0e0d0c0b0a090807060504030201, 8'h01, 8'h20};
    lv[1] = '{SEL_MSG, {8'h5A, 240'h0, 8'hC3}, 8'hC3, 8'h5A};
    lv[2] = '{SEL_MOD, {16{16'h1234}}, 8'h34, 8'h12};
`ifdef RSA_SERDES_BSWAP_EN
    lv[0].exp_first = 8'h20; lv[0].exp_last = 8'h01;
    lv[1].exp_first = 8'h5A; lv[1].exp_last = 8'hC3;
    lv[2].exp_first = 8'h12; lv[2].exp_last = 8'h34;
`endif

    tick(); tick();
    chk("rst_in_ready", a_in_ready, 1);
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_out_data", a_out_data, 0);
    chk("rst_we_oe", {a_core_we, a_core_oe}, 0);
    chk("rst_sel_addr_data", {a_core_reg_sel, a_core_addr, a_core_data_i}, 0);
    chk("rst_busy", a_busy, 0);
    reset = 1'b0;
    tick();
    $display("reset released in_ready=%0b busy=%0b", a_in_ready, a_busy);

    for (int v = 0; v < 3; v++) begin
      in_data  = lv[v].data;
      in_sel   = lv[v].sel;
      in_valid = 1'b1;
      chk("load_in_ready", a_in_ready, 1);
      tick();
      in_valid = 1'b0;
      n = 0;
      first_b = a_core_data_i;
      last_b  = 8'h00;
      while (a_core_we === 1'b1 && n < 200) begin
        chk("load_beat", {a_core_reg_sel, a_core_addr, a_core_data_i},
            {lv[v].sel, 5'((n / A_STEP) % 32), byte_of(lv[v].data, (n / A_STEP) % 32)});
        last_b = a_core_data_i;
        tick();
        n++;
      end
      chk("load_first_byte", first_b, lv[v].exp_first);
      chk("load_last_byte", last_b, lv[v].exp_last);
      chk("load_we_cycles", n, 64);
      chk("load_end_idle", {a_in_ready, a_busy}, 2'b10);
      chk("load_end_zero", {a_core_reg_sel, a_core_addr, a_core_data_i}, 0);
      $display("load sel=%0d first=%02h last=%02h we_cycles=%0d", lv[v].sel, first_b, last_b, n);
    end

    unload_req_b = 1'b1;
    chk("unl_in_ready", b_in_ready, 1);
    tick();
    unload_req_b = 1'b0;
    chk("unl_oe_rise", {b_core_oe, b_core_we}, 2'b10);
    chk("unl_addr0", b_core_addr, 0);
    n = 0;
    while (b_out_valid !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk("unl_latency", n, 35);
    chk("unl_data", b_out_data, unload_word());
    chk("unl_hold_busy", {b_in_ready, b_busy}, 2'b01);
    $display("unload step=1 lat=3 out_valid_after=%0d data=%0h", n, b_out_data);

    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_valid", b_out_valid, 1);
      chk("bp_data", b_out_data, unload_word());
      chk("bp_in_ready", b_in_ready, 0);
    end
    out_ready_b = 1'b1;
    tick();
    out_ready_b = 1'b0;
    chk("bp_accept_valid", b_out_valid, 0);
    chk("bp_accept_idle", b_in_ready, 1);
    $display("backpressure 10 cycles then accept in_ready=%0b", b_in_ready);

    in_data      = lv[0].data;
    in_sel       = SEL_EXP;
    in_valid     = 1'b1;
    unload_req_a = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("sim_load_first", {a_core_we, a_core_oe}, 2'b10);
    n = 0;
    while (a_core_we === 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk("sim_load_cycles", n, 64);
    chk("sim_idle_gap", {a_in_ready, a_core_oe}, 2'b10);
    tick();
    unload_req_a = 1'b0;
    chk("sim_unload_start", a_core_oe, 1);
    n = 0;
    while (a_out_valid !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    chk("sim_unload_latency", n, 66);
    chk("sim_unload_data", a_out_data, unload_word());
    tick();
    chk("sim_accept", {a_out_valid, a_in_ready}, 2'b01);
    $display("simultaneous load then unload step=2 out_valid_after=%0d", n);

    in_data  = lv[2].data;
    in_sel   = SEL_MOD;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (a_core_addr !== 5'd12 && n < 200) begin
      tick();
      n++;
    end
    chk("rstmid_reach12", {a_core_we, a_core_addr}, {1'b1, 5'd12});
    reset = 1'b1;
    #1;
    chk("rstmid_we_async", a_core_we, 0);
    chk("rstmid_state", {a_in_ready, a_busy, a_core_addr}, {2'b10, 5'd0});
    tick(); tick();
    reset = 1'b0;
    chk("rstmid_after", {a_in_ready, a_core_addr, a_core_reg_sel}, {1'b1, 5'd0, 2'b00});
    stray = 0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (a_core_we !== 1'b0) stray++;
    end
    chk("rstmid_no_stray", stray, 0);
    $display("reset mid-load at addr 12 stray_writes=%0d", stray);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
